// File: rtl/processor_defines.sv
// ---------------------------------------------------------------------------
// processor_defines
//   Definitions shared by the fetch, decode and jump stages: address and
//   instruction widths, the default reset PC, the fetch FSM state encoding
//   and the instruction-buffer entry layout.
// ---------------------------------------------------------------------------
package processor_defines;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned INST_W = 32;

   localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // RUN: nothing outstanding; WAIT: one request outstanding, response kept;
   // WAIT_DROP: one request outstanding, response will be thrown away.
   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_WAIT      = 2'd1,
      ST_WAIT_DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   // Instructions are word aligned; the low two address bits are ignored.
   function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
//   Two-entry FIFO holding fetched {pc, instruction} pairs for decode.
//   Ports:
//     i_clk, i_rst    clock, synchronous active-low reset
//     push/push_entry write one entry (ignored when full without a pop)
//     pop             remove head entry (ignored when empty)
//     flush           empty the FIFO; overrides push and pop
//     head_entry      oldest entry
//     count           number of valid entries (0..2)
// ---------------------------------------------------------------------------
module fetch_buffer
   import processor_defines::*;
#(
   parameter int unsigned DEPTH = 2
)
(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head_entry,
   output logic [1:0]   count
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   fetch_entry_t mem_q [2];
   fetch_entry_t mem_d [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         do_push, do_pop;

   always_comb begin
      do_pop   = pop & (count_q != 2'd0) & ~flush;
      do_push  = push & ((count_q != FULL) | do_pop) & ~flush;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         // With two entries a one-bit pointer simply toggles on each access.
         if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage carries no reset; validity is tracked by count_q.
   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
   end

   assign head_entry = mem_q[rd_ptr_q];
   assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch: issues word fetches to instruction memory, keeps at
//   most one request outstanding, buffers returned words in a 2-entry FIFO
//   and hands them to decode. A redirect flushes the buffer, reloads the PC
//   and discards any response still in flight.
//   Ports:
//     i_clk, i_rst                      clock, synchronous active-low reset
//     redirect_valid, redirect_pc       PC redirect from jump/branch stage
//     imem_req_valid/addr/ready         fetch request handshake
//     imem_resp_valid/data              fetch response (no backpressure)
//     inst_valid/data/pc, inst_ready    instruction handshake toward decode
//     misalign_err                      one-cycle pulse after a redirect
//                                       whose target has nonzero bits [1:0]
// ---------------------------------------------------------------------------
module fetch_unit
   import processor_defines::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int unsigned BUF_DEPTH = 2
)
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic        misalign_err
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  out_pc_q, out_pc_d;
   logic         misalign_q, misalign_d;

   logic [1:0]   buf_count;
   logic         req_fire, pop, push;
   fetch_entry_t push_entry, head_entry;

   // Outputs are gated with i_rst so nothing is offered while reset is held.
   // imem_req_* depend only on registered state and the redirect input,
   // never on the memory response.
   assign imem_req_valid = i_rst & (state_q == ST_RUN) &
                           (buf_count < 2'(BUF_DEPTH)) & ~redirect_valid;
   assign imem_req_addr  = pc_q;
   assign inst_valid     = i_rst & (buf_count != 2'd0) & ~redirect_valid;
   assign inst_data      = head_entry.inst;
   assign inst_pc        = head_entry.pc;
   assign misalign_err   = misalign_q;

   assign req_fire   = imem_req_valid & imem_req_ready;
   assign pop        = inst_valid & inst_ready;
   assign push       = (state_q == ST_WAIT) & imem_resp_valid & ~redirect_valid;
   assign push_entry = {out_pc_q, imem_resp_data};

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      out_pc_d   = out_pc_q;
      misalign_d = redirect_valid & (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
         pc_d = align_word(redirect_pc);
         case (state_q)
            // A response landing in the redirect cycle is consumed and
            // dropped; otherwise the in-flight one must still be absorbed.
            ST_WAIT, ST_WAIT_DROP: state_d = imem_resp_valid ? ST_RUN : ST_WAIT_DROP;
            default:               state_d = ST_RUN;
         endcase
      end else begin
         case (state_q)
            ST_RUN: begin
               if (req_fire) begin
                  pc_d     = pc_q + 32'd4;
                  out_pc_d = pc_q;
                  state_d  = ST_WAIT;
               end
            end
            ST_WAIT, ST_WAIT_DROP: begin
               if (imem_resp_valid) begin
                  state_d = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         out_pc_q   <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         out_pc_q   <= out_pc_d;
         misalign_q <= misalign_d;
      end
   end

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_buffer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redirect_valid),
      .head_entry (head_entry),
      .count      (buf_count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Directed scenarios against fetch_unit with a transaction-level model:
//   the model keeps the expected buffer contents as a queue, the next fetch
//   PC and whether a fetch is in flight (and whether it is to be discarded).
//   Memory returns mem_word(addr) a programmable number of cycles after
//   acceptance. One line is printed per instruction handed to decode.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b1;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b1;
   logic        misalign_err;

   always #5 i_clk = ~i_clk;

   fetch_unit #(
      .RESET_PC  (RESET_PC),
      .BUF_DEPTH (2)
   ) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst_data       (inst_data),
      .inst_pc         (inst_pc),
      .inst_ready      (inst_ready),
      .misalign_err    (misalign_err)
   );

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 | {16'h0000, a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // ---------------- memory responder ----------------
   int          lat = 1;
   int          resp_cnt = 0;
   logic [31:0] resp_addr = 32'h0;
   logic        seen_fire;
   logic [31:0] seen_addr;

   always begin
      @(negedge i_clk);
      seen_fire = imem_req_valid && imem_req_ready;
      seen_addr = imem_req_addr;
      @(posedge i_clk);
      #1;
      imem_resp_valid = 1'b0;
      if (seen_fire) begin
         resp_cnt  = lat;
         resp_addr = seen_addr;
      end
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(resp_addr);
         end
      end
   end

   // ---------------- model + per-cycle compare ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } ent_t;

   ent_t        m_q[$];
   ent_t        log_q[$];
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_out_pc = 32'h0;
   bit          m_out = 1'b0;
   bit          m_drop = 1'b0;
   bit          m_mis = 1'b0;
   bit          m_live = 1'b0;
   bit          exp_rv, exp_iv, m_fire, m_take;

   always begin
      @(negedge i_clk);
      if (m_live) begin
         exp_rv = i_rst && !m_out && (m_q.size() < 2) && !redirect_valid;
         exp_iv = i_rst && (m_q.size() > 0) && !redirect_valid;
         chk1("req_valid", imem_req_valid, exp_rv);
         if (i_rst) chk("req_addr", imem_req_addr, m_pc);
         chk1("inst_valid", inst_valid, exp_iv);
         if (exp_iv) begin
            chk("inst_pc", inst_pc, m_q[0].pc);
            chk("inst_data", inst_data, m_q[0].data);
         end
         chk1("misalign_err", misalign_err, m_mis);
      end
      if (inst_valid && inst_ready) begin
         log_q.push_back('{inst_pc, inst_data});
         $display("decode pc=%h inst=%h", inst_pc, inst_data);
      end
      @(posedge i_clk);
      if (!i_rst) begin
         m_pc   = RESET_PC;
         m_out  = 1'b0;
         m_drop = 1'b0;
         m_mis  = 1'b0;
         m_q.delete();
      end else begin
         m_fire = !m_out && (m_q.size() < 2) && !redirect_valid && imem_req_ready;
         m_take = m_out && imem_resp_valid;
         m_mis  = redirect_valid && (redirect_pc[1:0] != 2'b00);
         if (redirect_valid) begin
            m_q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            if (m_take) begin
               m_out  = 1'b0;
               m_drop = 1'b0;
            end else if (m_out) begin
               m_drop = 1'b1;
            end
         end else begin
            if ((m_q.size() > 0) && inst_ready) void'(m_q.pop_front());
            if (m_take) begin
               if (!m_drop) m_q.push_back('{m_out_pc, mem_word(m_out_pc)});
               m_out  = 1'b0;
               m_drop = 1'b0;
            end
            if (m_fire) begin
               m_out    = 1'b1;
               m_out_pc = m_pc;
               m_pc     = m_pc + 32'd4;
            end
         end
      end
      m_live = 1'b1;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic wait_fire(input string name);
      bit found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge i_clk);
         if (imem_req_valid && imem_req_ready) found = 1'b1;
         @(posedge i_clk);
         #1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL %s: no request accepted within 20 cycles, expected one", name);
      end
   endtask

   task automatic chk_log(input string name, input int idx, input logic [31:0] pc);
      checks++;
      if (log_q.size() <= idx) begin
         errors++;
         $display("FAIL %s: only %0d instructions delivered, expected entry %0d", name, log_q.size(), idx);
      end else begin
         checks--;
         chk({name, "_pc"}, log_q[idx].pc, pc);
         chk({name, "_data"}, log_q[idx].data, mem_word(pc));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
      $fatal(1);
   end

   // ---------------- directed scenarios ----------------
   initial begin
      // Reset held: nothing offered.
      tick(3);
      @(negedge i_clk);
      chk1("rst_req_valid", imem_req_valid, 1'b0);
      chk1("rst_inst_valid", inst_valid, 1'b0);
      chk1("rst_misalign", misalign_err, 1'b0);
      @(posedge i_clk);
      #1;

      // Sequential stream after reset, 1-cycle memory.
      i_rst = 1'b1;
      @(negedge i_clk);
      chk1("first_req_valid", imem_req_valid, 1'b1);
      chk("first_req_addr", imem_req_addr, 32'h0000_0000);
      tick(12);
      chk_log("seq0", 0, 32'h0000_0000);
      chk_log("seq1", 1, 32'h0000_0004);
      chk_log("seq2", 2, 32'h0000_0008);
      chk("seq0_data_lit", log_q[0].data, 32'hC0DE_0000);

      // Decode stalled: buffer fills with two entries, fetching stops.
      inst_ready     = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0040;
      tick(1);
      redirect_valid = 1'b0;
      tick(10);
      @(negedge i_clk);
      chk1("full_req_valid", imem_req_valid, 1'b0);
      chk1("full_inst_valid", inst_valid, 1'b1);
      chk("full_head_pc", inst_pc, 32'h0000_0040);
      @(posedge i_clk);
      #1;
      log_q.delete();
      inst_ready = 1'b1;
      tick(8);
      chk_log("drain0", 0, 32'h0000_0040);
      chk_log("drain1", 1, 32'h0000_0044);
      chk_log("resume", 2, 32'h0000_0048);

      // Redirect while waiting; the in-flight response arrives a cycle later.
      lat = 2;
      wait_fire("t_wait_fire");
      log_q.delete();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      tick(1);
      redirect_valid = 1'b0;
      tick(10);
      chk_log("waitdrop0", 0, 32'h0000_0100);
      chk_log("waitdrop1", 1, 32'h0000_0104);

      // Redirect in the same cycle as the response.
      lat = 1;
      wait_fire("t_same_fire");
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      tick(1);
      redirect_valid = 1'b0;
      @(negedge i_clk);
      chk1("same_req_valid", imem_req_valid, 1'b1);
      chk("same_req_addr", imem_req_addr, 32'h0000_0200);
      chk1("same_inst_valid", inst_valid, 1'b0);
      @(posedge i_clk);
      #1;
      tick(4);

      // Misaligned redirect target.
      log_q.delete();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      tick(1);
      redirect_valid = 1'b0;
      @(negedge i_clk);
      chk1("mis_pulse", misalign_err, 1'b1);
      chk("mis_addr", imem_req_addr, 32'h0000_0100);
      @(posedge i_clk);
      #1;
      @(negedge i_clk);
      chk1("mis_clear", misalign_err, 1'b0);
      @(posedge i_clk);
      #1;
      tick(8);
      chk_log("mis_first", 0, 32'h0000_0100);

      // Reset with one entry buffered and one fetch outstanding.
      inst_ready     = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0300;
      tick(1);
      redirect_valid = 1'b0;
      lat = 3;
      wait_fire("t_rst_fire_a");
      wait_fire("t_rst_fire_b");
      i_rst          = 1'b0;
      imem_req_ready = 1'b0;
      tick(2);
      i_rst = 1'b1;
      @(negedge i_clk);
      chk1("rel_req_valid", imem_req_valid, 1'b1);
      chk("rel_req_addr", imem_req_addr, RESET_PC);
      chk1("rel_inst_valid", inst_valid, 1'b0);
      @(posedge i_clk);
      #1;
      @(negedge i_clk);
      chk1("stale_ignored", inst_valid, 1'b0);
      @(posedge i_clk);
      #1;
      log_q.delete();
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      tick(12);
      chk_log("rel_first", 0, 32'h0000_0000);
      chk_log("rel_second", 1, 32'h0000_0004);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
